// File: rtl/nn_and_trainer.sv
// nn_and_trainer: on-chip perceptron trainer for a 2-input neuron.
//
// Walks the four {x1,x0} input patterns, thresholds bias + x0*w0 + x1*w1
// against zero and applies the perceptron rule until a whole epoch passes
// with no error or MAX_EPOCHS epochs have run. The live weight registers
// feed the inference neuron directly.
//
// Optional feature: define NN_TRAIN_SAT_EN to saturate updated weights and
// bias to [-128,127]; otherwise updates wrap (keep the low 8 bits).
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start               one-cycle request, sampled only in IDLE
//   target[3:0]         desired output per pattern, target[{x1,x0}]
//   w0/w1/bias_init     signed initial values, loaded on accepted start
//   busy                high while training (EVAL/UPDATE/CHECK)
//   done                one-cycle pulse when training ends
//   converged           1 = clean epoch reached; held until next start
//   w0_o/w1_o/bias_o    live signed weight/bias registers
//   epoch_cnt           epochs executed, including the final clean one
module nn_and_trainer #(
  parameter int LR         = 1,
  parameter int MAX_EPOCHS = 32,
  parameter int EPW        = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [3:0]             target,
  input  logic signed [7:0]      w0_init,
  input  logic signed [7:0]      w1_init,
  input  logic signed [7:0]      bias_init,
  output logic                   busy,
  output logic                   done,
  output logic                   converged,
  output logic signed [7:0]      w0_o,
  output logic signed [7:0]      w1_o,
  output logic signed [7:0]      bias_o,
  output logic [EPW-1:0]         epoch_cnt
);

  typedef enum logic [2:0] {IDLE, EVAL, UPDATE, CHECK, DONE} state_t;

  localparam logic signed [15:0] LR16   = 16'(LR);
  localparam logic [EPW-1:0]     EP_MAX = EPW'(MAX_EPOCHS);

  state_t             state, state_d;
  logic signed [7:0]  w0, w1, bias;
  logic [3:0]         tgt;
  logic [1:0]         p;
  logic signed [1:0]  e, e_d;
  logic               err_flag;
  logic [EPW-1:0]     ep_inc;

  logic signed [15:0] w0_x, w1_x, b_x, sum, step;
  logic               y;

  // Reduce a 16-bit update result back to the 8-bit register width.
  function automatic logic signed [7:0] reduce(input logic signed [15:0] v);
`ifdef NN_TRAIN_SAT_EN
    if (v > 16'sd127)       return 8'sh7f;
    else if (v < -16'sd128) return 8'sh80;
    else                    return 8'(v);
`else
    return 8'(v);
`endif
  endfunction

  assign w0_x = {{8{w0[7]}}, w0};
  assign w1_x = {{8{w1[7]}}, w1};
  assign b_x  = {{8{bias[7]}}, bias};

  // Neuron pre-activation for the current pattern; x0 = p[0], x1 = p[1].
  assign sum = b_x + (p[0] ? w0_x : 16'sd0) + (p[1] ? w1_x : 16'sd0);
  assign y   = (sum > 16'sd0);

  // e = target - y, restricted to {-1,0,+1}
  always_comb begin
    e_d = 2'sb00;
    unique case ({tgt[p], y})
      2'b10:   e_d = 2'sb01;
      2'b01:   e_d = 2'sb11;
      default: e_d = 2'sb00;
    endcase
  end

  // Only meaningful when e != 0.
  assign step   = e[1] ? -LR16 : LR16;
  assign ep_inc = epoch_cnt + EPW'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = EVAL;
      EVAL:    state_d = UPDATE;
      UPDATE:  state_d = (p == 2'd3) ? CHECK : EVAL;
      CHECK:   begin
        if (!err_flag || ep_inc == EP_MAX) state_d = DONE;
        else                               state_d = EVAL;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      EVAL, UPDATE, CHECK: busy = 1'b1;
      DONE:                done = 1'b1;
      default:             ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0        <= '0;
      w1        <= '0;
      bias      <= '0;
      tgt       <= '0;
      p         <= '0;
      e         <= '0;
      err_flag  <= 1'b0;
      converged <= 1'b0;
      epoch_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          w0        <= w0_init;
          w1        <= w1_init;
          bias      <= bias_init;
          tgt       <= target;
          epoch_cnt <= '0;
          converged <= 1'b0;
          err_flag  <= 1'b0;
          p         <= '0;
        end
        EVAL: e <= e_d;
        UPDATE: begin
          if (e != 2'sb00) begin
            if (p[0]) w0 <= reduce(w0_x + step);
            if (p[1]) w1 <= reduce(w1_x + step);
            bias     <= reduce(b_x + step);
            err_flag <= 1'b1;
          end
          // p==3 wraps to 0, ready for the next epoch
          p <= p + 2'd1;
        end
        CHECK: begin
          epoch_cnt <= ep_inc;
          if (!err_flag)             converged <= 1'b1;
          else if (ep_inc == EP_MAX) converged <= 1'b0;
          else begin
            err_flag <= 1'b0;
            p        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign w0_o   = w0;
  assign w1_o   = w1;
  assign bias_o = bias;

endmodule

// File: tb/tb_nn_and_trainer.sv
// Scoreboard bench for nn_and_trainer: each accepted start pushes the
// reference result; a monitor pops and compares on every done pulse.
module tb_nn_and_trainer;

  localparam int LR         = 1;
  localparam int MAX_EPOCHS = 32;
  localparam int EPW        = 6;

  logic                 clk = 1'b0;
  logic                 rst_n, start;
  logic [3:0]           target;
  logic signed [7:0]    w0_init, w1_init, bias_init;
  logic                 busy, done, converged;
  logic signed [7:0]    w0_o, w1_o, bias_o;
  logic [EPW-1:0]       epoch_cnt;

  nn_and_trainer #(.LR(LR), .MAX_EPOCHS(MAX_EPOCHS), .EPW(EPW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target),
    .w0_init(w0_init), .w1_init(w1_init), .bias_init(bias_init),
    .busy(busy), .done(done), .converged(converged),
    .w0_o(w0_o), .w1_o(w1_o), .bias_o(bias_o), .epoch_cnt(epoch_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int conv; int ep; int w0; int w1; int b; int t0;
  } exp_t;
  exp_t q[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Register-width reduction of an update result.
  function automatic int fix(input int v);
`ifdef NN_TRAIN_SAT_EN
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
`else
    logic signed [7:0] t;
    t = 8'(v);
    return int'(t);
`endif
  endfunction

  // Reference: plain perceptron training loop over whole epochs.
  function automatic exp_t model(input int t, input int a, input int b, input int c);
    exp_t r;
    int w0, w1, bs, ep;
    bit err;
    w0 = a; w1 = b; bs = c; ep = 0;
    do begin
      err = 0;
      for (int p = 0; p < 4; p++) begin
        int x0, x1, s, y, e;
        x0 = p % 2;
        x1 = p / 2;
        s  = bs + x0 * w0 + x1 * w1;
        y  = (s > 0) ? 1 : 0;
        e  = ((t >> p) & 1) - y;
        if (e != 0) begin
          err = 1;
          w0 = fix(w0 + LR * e * x0);
          w1 = fix(w1 + LR * e * x1);
          bs = fix(bs + LR * e);
        end
      end
      ep++;
    end while (err && ep < MAX_EPOCHS);
    r.conv = err ? 0 : 1;
    r.ep = ep; r.w0 = w0; r.w1 = w1; r.b = bs; r.t0 = 0;
    return r;
  endfunction

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("latency",   cyc - x.t0, 9 * x.ep);
        chk("converged", int'(converged), x.conv);
        chk("epoch_cnt", int'(epoch_cnt), x.ep);
        chk("w0_o",      int'(w0_o), x.w0);
        chk("w1_o",      int'(w1_o), x.w1);
        chk("bias_o",    int'(bias_o), x.b);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  // Called at a negedge with the DUT in IDLE; returns one negedge after the
  // start-sampling edge.
  task automatic start_case(input logic [3:0] t, input int a, input int b, input int c);
    exp_t x;
    target = t; w0_init = 8'(a); w1_init = 8'(b); bias_init = 8'(c);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    x = model(int'(t), int'(w0_init), int'(w1_init), int'(bias_init));
    x.t0 = cyc;
    q.push_back(x);
    chk("busy_after_start", int'(busy), 1);
  endtask

  // Wait for done (bounded); optionally drive start during the DONE cycle.
  // Returns at the negedge after DONE, with the DUT back in IDLE.
  task automatic wait_done(input bit poke);
    int n;
    n = 0;
    while (!done && n < 9 * MAX_EPOCHS + 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_and_result(input string tag);
    chk({tag, "_conv"}, int'(converged), 1);
    chk({tag, "_ep"},   int'(epoch_cnt), 6);
    chk({tag, "_w0"},   int'(w0_o), 1);
    chk({tag, "_w1"},   int'(w1_o), 2);
    chk({tag, "_bias"}, int'(bias_o), -2);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; target = 4'b1000;
    w0_init = 8'sd0; w1_init = 8'sd0; bias_init = 8'sd0;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_conv", int'(converged), 0);
    chk("rst_w0",   int'(w0_o), 0);
    chk("rst_ep",   int'(epoch_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // AND from zero
    start_case(4'b1000, 0, 0, 0);
    wait_done(1'b0);
    chk_and_result("and");

    // XOR never converges
    start_case(4'b0110, 0, 0, 0);
    wait_done(1'b0);
    chk("xor_conv", int'(converged), 0);
    chk("xor_ep",   int'(epoch_cnt), MAX_EPOCHS);

    // Saturation / wrap boundary
    start_case(4'b1111, 127, 0, -128);
    repeat (2) @(negedge clk);
    chk("sat_bias_p0", int'(bias_o), -127);
    repeat (2) @(negedge clk);
`ifdef NN_TRAIN_SAT_EN
    chk("sat_w0_p1", int'(w0_o), 127);
`else
    chk("sat_w0_p1", int'(w0_o), -128);
`endif
    wait_done(1'b0);

    // Already correct: one clean epoch, weights untouched; start during
    // DONE must not launch a new run.
    start_case(4'b1000, 20, 20, -30);
    wait_done(1'b1);
    chk("ok_ep",   int'(epoch_cnt), 1);
    chk("ok_w0",   int'(w0_o), 20);
    chk("ok_w1",   int'(w1_o), 20);
    chk("ok_bias", int'(bias_o), -30);
    @(negedge clk);
    chk("start_in_done_ignored", int'(busy), 0);

    // Reset during epoch 2, no expectation queued: any done is an error.
    target = 4'b1000; w0_init = 8'sd0; w1_init = 8'sd0; bias_init = 8'sd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_w0",   int'(w0_o), 0);
    chk("midrst_w1",   int'(w1_o), 0);
    chk("midrst_bias", int'(bias_o), 0);
    chk("midrst_ep",   int'(epoch_cnt), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_case(4'b1000, 0, 0, 0);
    wait_done(1'b0);
    chk_and_result("and_after_rst");

    // Inputs and start toggling mid-run must not disturb the run.
    start_case(4'b1000, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      target    = 4'($urandom);
      w0_init   = 8'($urandom);
      w1_init   = 8'($urandom);
      bias_init = 8'($urandom);
      start     = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(1'b0);
    chk_and_result("and_noisy");

    // Randomized runs against the reference model
    for (int i = 0; i < 25; i++) begin
      int a, b, c;
      if (i % 2 == 0) begin
        a = int'($urandom_range(0, 80)) - 40;
        b = int'($urandom_range(0, 80)) - 40;
        c = int'($urandom_range(0, 80)) - 40;
      end else begin
        a = int'($urandom_range(0, 255)) - 128;
        b = int'($urandom_range(0, 255)) - 128;
        c = int'($urandom_range(0, 255)) - 128;
      end
      start_case(4'($urandom), a, b, c);
      wait_done(1'b0);
    end

    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
